// File: rtl/render_pkg.sv
// render_pkg: shared constants, field helpers and line entry type for the scanline renderer
package render_pkg;
    localparam int N_OBJ = 20;
    localparam int N_LIFE = 10;
    localparam int MAX_PER_LINE = 8;
    localparam int N_CAND = N_LIFE + N_OBJ;
    localparam int X_HI = 31;
    localparam int X_LO = 16;
    localparam int Y_HI = 15;
    localparam int Y_LO = 0;
    typedef enum logic [1:0] {IDLE, SCAN, READY} scan_state_t;
    typedef struct packed {
        logic [17:0] sx_start;
        logic [17:0] sx_end;
        logic [9:0]  type_code;
        logic        is_life;
    } line_entry_t;
    function automatic logic [15:0] hi_field(input logic [31:0] v);
        return v[X_HI:X_LO];
    endfunction
    function automatic logic [15:0] lo_field(input logic [31:0] v);
        return v[Y_HI:Y_LO];
    endfunction
endpackage

// File: rtl/scan_candidate_test.sv
// scan_candidate_test: decides whether one entity crosses a scanline and builds its screen-space entry
module scan_candidate_test
    import render_pkg::*;
(
    input  logic [31:0]  coord,
    input  logic [31:0]  size,
    input  logic [9:0]   type_code,
    input  logic         is_life,
    input  logic [9:0]   line,
    input  logic [15:0]  cam_x,
    output logic         pass,
    output line_entry_t  entry
);
    logic [15:0] x, y, w, h;
    logic [16:0] y_end;
    always_comb begin
        x = hi_field(coord);
        y = lo_field(coord);
        w = hi_field(size);
        h = lo_field(size);
        y_end = {1'b0, y} + {1'b0, h};
        pass = (|w) && (|h) && ({6'b0, line} >= y) && ({7'b0, line} < y_end);
        entry.sx_start = {2'b0, x} - {2'b0, cam_x};
        entry.sx_end = entry.sx_start + {2'b0, w};
        entry.type_code = type_code;
        entry.is_life = is_life;
    end
endmodule

// File: rtl/line_object_scanner.sv
// line_object_scanner: per-scanline entity selection during hblank and per-pixel priority hit lookup
module line_object_scanner
    import render_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [32*N_OBJ-1:0]  obj_coord,
    input  logic [32*N_OBJ-1:0]  obj_size,
    input  logic [10*N_OBJ-1:0]  obj_type,
    input  logic [32*N_LIFE-1:0] life_coord,
    input  logic [32*N_LIFE-1:0] life_size,
    input  logic [10*N_LIFE-1:0] life_type,
    input  logic [15:0]          cam_x,
    input  logic                 line_start,
    input  logic [9:0]           next_line,
    input  logic                 pixel_valid,
    input  logic [9:0]           pixel_x,
    output logic                 hit,
    output logic [9:0]           hit_type,
    output logic                 hit_is_life,
    output logic                 scan_busy,
    output logic                 overflow
);
    scan_state_t state;
    logic [31:0] oc_q [N_OBJ];
    logic [31:0] os_q [N_OBJ];
    logic [9:0]  ot_q [N_OBJ];
    logic [31:0] lc_q [N_LIFE];
    logic [31:0] ls_q [N_LIFE];
    logic [9:0]  lt_q [N_LIFE];
    logic [15:0] cam_q;
    logic [9:0]  line_q;
    logic [4:0]  k;
    logic [3:0]  cnt;
    logic        full;
    logic        c_life, c_pass;
    logic [3:0]  li;
    logic [4:0]  oi;
    logic [31:0] c_coord, c_size;
    logic [9:0]  c_type;
    line_entry_t c_entry;
    line_entry_t ents [MAX_PER_LINE];
    logic [17:0] px_ext;
    logic        m_hit, m_life, q_hit;
    logic [9:0]  m_type;
    always_ff @(posedge clk) begin
        if (line_start) begin
            for (int i = 0; i < N_OBJ; i++) begin
                oc_q[i] <= obj_coord[32*i +: 32];
                os_q[i] <= obj_size[32*i +: 32];
                ot_q[i] <= obj_type[10*i +: 10];
            end
            for (int i = 0; i < N_LIFE; i++) begin
                lc_q[i] <= life_coord[32*i +: 32];
                ls_q[i] <= life_size[32*i +: 32];
                lt_q[i] <= life_type[10*i +: 10];
            end
            cam_q <= cam_x;
            line_q <= next_line;
        end
    end
    // lives are visited first, highest slot (Mario) leading, so list order encodes priority
    always_comb begin
        c_life = k < 5'(N_LIFE);
        li = c_life ? 4'(N_LIFE - 1) - k[3:0] : '0;
        oi = c_life ? '0 : k - 5'(N_LIFE);
        c_coord = c_life ? lc_q[li] : oc_q[oi];
        c_size = c_life ? ls_q[li] : os_q[oi];
        c_type = c_life ? lt_q[li] : ot_q[oi];
    end
    scan_candidate_test u_test (
        .coord(c_coord),
        .size(c_size),
        .type_code(c_type),
        .is_life(c_life),
        .line(line_q),
        .cam_x(cam_q),
        .pass(c_pass),
        .entry(c_entry)
    );
    assign full = cnt == 4'(MAX_PER_LINE);
    assign scan_busy = state == SCAN;
    always_ff @(posedge clk) begin
        if (state == SCAN && !line_start && c_pass && !full)
            ents[cnt[2:0]] <= c_entry;
    end
    assign px_ext = {8'b0, pixel_x};
    // walk from the back so the lowest matching index is the one left standing
    always_comb begin
        m_hit = 1'b0;
        m_type = '0;
        m_life = 1'b0;
        for (int i = MAX_PER_LINE - 1; i >= 0; i--) begin
            if (4'(i) < cnt && $signed(ents[i].sx_start) <= $signed(px_ext) && $signed(px_ext) < $signed(ents[i].sx_end)) begin
                m_hit = 1'b1;
                m_type = ents[i].type_code;
                m_life = ents[i].is_life;
            end
        end
    end
    assign q_hit = state == READY && pixel_valid && m_hit;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            k <= '0;
            cnt <= '0;
            overflow <= 1'b0;
            hit <= 1'b0;
            hit_type <= '0;
            hit_is_life <= 1'b0;
        end else begin
            hit <= q_hit;
            hit_type <= q_hit ? m_type : '0;
            hit_is_life <= q_hit && m_life;
            if (line_start) begin
                state <= SCAN;
                k <= '0;
                cnt <= '0;
                overflow <= 1'b0;
            end else if (state == SCAN) begin
                if (c_pass && full)
                    overflow <= 1'b1;
                if (c_pass && !full)
                    cnt <= cnt + 4'd1;
                k <= k + 5'd1;
                if (k == 5'(N_CAND - 1))
                    state <= READY;
            end
        end
    end
endmodule
